// File: rtl/control_pc.sv
// control_pc: program counter and subroutine control stage feeding the
// program stack `pila`. Produces the fetch address, pushes return addresses
// on llamada, pops on retorno, and locks into ERROR on stack over/underflow.
// Optional build macro CONTROL_PC_SALTO_RELATIVO_EN: salto adds destino to pc
// as a two's-complement offset instead of loading it as an absolute address.
module control_pc #(
  parameter int unsigned ANCHO_PC    = 10,
  parameter int unsigned PROFUNDIDAD = 63,
  parameter logic [ANCHO_PC-1:0] VECTOR_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                habilita,
  input  logic                salto,
  input  logic                llamada,
  input  logic                retorno,
  input  logic [ANCHO_PC-1:0] destino,
  input  logic [ANCHO_PC-1:0] datoPila,
  output logic [ANCHO_PC-1:0] pc,
  output logic                pilaActiva,
  output logic                pilaPush,
  output logic [ANCHO_PC-1:0] pilaDatos,
  output logic [6:0]          profundidad,
  output logic                error
);

  typedef enum logic [1:0] {
    ST_INICIO  = 2'd0,
    ST_EJECUTA = 2'd1,
    ST_ERROR   = 2'd2
  } estado_t;

  localparam logic [6:0] PROF_MAX = 7'(PROFUNDIDAD);

  estado_t             estado_q, estado_d;
  logic [ANCHO_PC-1:0] pc_q, pc_d;
  logic [6:0]          prof_q, prof_d;
  logic [ANCHO_PC-1:0] pc_mas_uno;

  assign pc_mas_uno  = pc_q + 1'b1;
  assign pc          = pc_q;
  assign pilaDatos   = pc_mas_uno;
  assign profundidad = prof_q;
  assign error       = (estado_q == ST_ERROR);

  // State, PC and depth registers; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_INICIO;
      pc_q     <= VECTOR_RESET;
      prof_q   <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      prof_q   <= prof_d;
    end
  end

  // Next-state and stack commands; retorno > llamada > salto > sequential.
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    prof_d     = prof_q;
    pilaActiva = 1'b0;
    pilaPush   = 1'b0;
    case (estado_q)
      ST_INICIO: estado_d = ST_EJECUTA;
      ST_EJECUTA: begin
        if (habilita) begin
          if (retorno) begin
            if (prof_q != '0) begin
              pilaActiva = 1'b1;
              pc_d       = datoPila;
              prof_d     = prof_q - 7'd1;
            end else begin
              estado_d = ST_ERROR;
            end
          end else if (llamada) begin
            if (prof_q < PROF_MAX) begin
              pilaActiva = 1'b1;
              pilaPush   = 1'b1;
              pc_d       = destino;
              prof_d     = prof_q + 7'd1;
            end else begin
              estado_d = ST_ERROR;
            end
          end else if (salto) begin
`ifdef CONTROL_PC_SALTO_RELATIVO_EN
            pc_d = pc_q + destino;
`else
            pc_d = destino;
`endif
          end else begin
            pc_d = pc_mas_uno;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_pc.md
Name: control_pc

Overview:
- Program counter and subroutine control stage that sits directly upstream of the program stack `pila`.
- Each cycle it produces the instruction fetch address.
- On a call it pushes the return address into `pila`. On a return it pops `pila` and reloads the PC from the stack's top-of-stack output.
- It tracks stack depth and halts in an error state on overflow or underflow, so the stack is never corrupted.

Parameters:
- ANCHO_PC, 10: PC width in bits. Must equal the DATA width of the connected `pila`.
- PROFUNDIDAD, 63: usable stack entries. The `pila` memory is 64 words and entry 0 is never written.
- VECTOR_RESET, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- habilita  input  1  stage enable. When 0, all state is held and no stack operation is issued.
- salto  input  1  unconditional jump this cycle.
- llamada  input  1  subroutine call this cycle.
- retorno  input  1  subroutine return this cycle.
- destino  input  ANCHO_PC  jump/call target.
- datoPila  input  ANCHO_PC  top-of-stack value, from `pila.salidaDatos`.
- pc  output  ANCHO_PC  current fetch address (registered).
- pilaActiva  output  1  drives `pila.activa` (combinational).
- pilaPush  output  1  drives `pila.push` (combinational).
- pilaDatos  output  ANCHO_PC  drives `pila.entradaDatos`; equals pc+1.
- profundidad  output  7  current number of pushed return addresses (registered).
- error  output  1  high while in the ERROR state.

Behaviour:
- Reset (asynchronous, reset=0): pc=VECTOR_RESET, profundidad=0, error=0, state=INICIO. pilaActiva=0 and pilaPush=0 while reset is asserted and while in INICIO.
- States:
  - INICIO: one cycle after reset release. pc is held, then the block goes to EJECUTA unconditionally.
  - EJECUTA: normal operation.
  - ERROR: absorbing. Only reset exits it.
- Command priority in EJECUTA with habilita=1: retorno > llamada > salto > sequential. Lower-priority commands asserted in the same cycle are ignored.
- Sequential: pc <= pc+1, modulo 2^ANCHO_PC (wraps to 0). No stack activity.
- salto: pc <= destino. No stack activity.
- llamada with profundidad<PROFUNDIDAD:
  - pilaActiva=1, pilaPush=1, pilaDatos=pc+1 (wrapped).
  - On the edge: pc <= destino, profundidad +1.
- llamada with profundidad==PROFUNDIDAD (overflow):
  - No stack activity; pc held.
  - Next state is ERROR; error=1 from the next cycle.
- retorno with profundidad>0:
  - pilaActiva=1, pilaPush=0.
  - On the same edge: pc <= datoPila (value sampled before the pop), profundidad −1.
  - Single cycle, no bubble. A retorno in the cycle immediately after a llamada or retorno is legal, because `pila` updates its output on the same edge.
- retorno with profundidad==0 (underflow): no stack activity, pc held, next state ERROR.
- habilita=0: pc, profundidad and state are held; pilaActiva=0.
- ERROR: pc, profundidad and error are held; pilaActiva=0 regardless of inputs.
- pilaDatos is always pc+1, independent of commands. pilaPush=0 whenever pilaActiva=0.
- Reset asserted mid-operation: all registers return to reset values immediately. The stack pointer inside `pila` is not reset, so software must not rely on stack contents after reset; profundidad=0 forbids any returns before the next call.

Optional Feature:
- Macro CONTROL_PC_SALTO_RELATIVO_EN.
- Defined: for salto only, destino is a two's-complement offset and pc <= pc+destino, modulo 2^ANCHO_PC. llamada still uses destino as an absolute target.
- Undefined: salto loads destino as an absolute address.

Test Plan:
- Reset, release, habilita=1, no commands, for 5 cycles -> pc sequence 0,0,1,2,3; pilaActiva never 1.
- At pc=5, llamada with destino=0x40 -> pilaActiva=1, pilaPush=1, pilaDatos=6 in that cycle; next pc=0x40, profundidad=1. A later retorno with datoPila=6 -> pilaActiva=1, pilaPush=0; next pc=6, profundidad=0.
- Nested calls 0x10→0x20→0x30 followed by three back-to-back returns, with `pila` connected -> pc returns to each caller+1 in reverse order, profundidad goes 3→0, no bubbles.
- retorno with profundidad=0 -> pc held, error=1 next cycle. Subsequent salto is ignored; reset clears error and pc=0.
- 63 calls followed by a 64th llamada -> no push on the 64th, error=1, profundidad stays 63.
- salto+llamada+retorno together at profundidad=1 -> retorno wins. With ANCHO_PC=10 at pc=0x3FF sequential -> pc=0. With CONTROL_PC_SALTO_RELATIVO_EN, salto with destino=0x3FE at pc=0x010 -> pc=0x00E.
